// File: rtl/msg_framer.sv
// Debug message framer: buffers one message of payload words, then emits a
// header word followed by the payload as a gap-free nd-qualified stream.
module msg_framer #(
  parameter int MSG_WIDTH  = 32,
  parameter int TYPE_WIDTH = 7,
  parameter int LEN_WIDTH  = 8,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_start,
  input  logic [TYPE_WIDTH-1:0] in_type,
  input  logic [MSG_WIDTH-2:0]  in_word,
  input  logic                  in_word_nd,
  input  logic                  in_end,
  output logic                  ready,
  output logic [MSG_WIDTH-1:0]  out_msg,
  output logic                  out_msg_nd,
  output logic                  error
);

  localparam int AW        = $clog2(DEPTH);
  localparam int CW        = AW + 1;
  localparam int SEQ_WIDTH = MSG_WIDTH - 1 - TYPE_WIDTH - LEN_WIDTH;

  typedef enum logic [1:0] {IDLE, COLLECT, HEADER, SEND} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic [AW-1:0]         rd_q, rd_d;
  logic [TYPE_WIDTH-1:0] type_q, type_d;
  logic [SEQ_WIDTH-1:0]  seq_q, seq_d;
  logic                  err_q, err_d;
  logic                  wr_en;
  logic [AW-1:0]         wr_idx;
  logic [MSG_WIDTH-2:0]  mem [DEPTH];
  logic [MSG_WIDTH-1:0]  last_q;
  logic [MSG_WIDTH-1:0]  header;
  logic [MSG_WIDTH-1:0]  payload;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rd_d    = rd_q;
    type_d  = type_q;
    seq_d   = seq_q;
    err_d   = err_q;
    wr_en   = 1'b0;
    wr_idx  = count_q[AW-1:0];
    unique case (state_q)
      IDLE: begin
        if (in_start) begin
          type_d  = in_type;
          count_d = '0;
          wr_idx  = '0;
          if (in_word_nd) begin
            wr_en   = 1'b1;
            count_d = CW'(1);
          end
          state_d = in_end ? HEADER : COLLECT;
        end else if (in_word_nd || in_end) begin
          err_d = 1'b1;
        end
      end
      COLLECT: begin
        if (in_start) err_d = 1'b1;
        if (in_word_nd) begin
          if (count_q < CW'(DEPTH)) begin
            wr_en   = 1'b1;
            count_d = count_q + CW'(1);
          end else begin
            err_d = 1'b1;
          end
        end
        if (in_end) state_d = HEADER;
      end
      HEADER: begin
        if (in_start || in_word_nd || in_end) err_d = 1'b1;
        seq_d   = seq_q + SEQ_WIDTH'(1);
        rd_d    = '0;
        state_d = (count_q == '0) ? IDLE : SEND;
      end
      SEND: begin
        if (in_start || in_word_nd || in_end) err_d = 1'b1;
        rd_d = rd_q + AW'(1);
        if (CW'(rd_q) == count_q - CW'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      rd_q    <= '0;
      type_q  <= '0;
      seq_q   <= '0;
      err_q   <= 1'b0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rd_q    <= rd_d;
      type_q  <= type_d;
      seq_q   <= seq_d;
      err_q   <= err_d;
      if (out_msg_nd) last_q <= out_msg;
    end
  end

  // Buffer contents need no reset: count_q gates every read.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= in_word;
  end

  assign header     = {1'b1, type_q, LEN_WIDTH'(count_q), seq_q};
  assign payload    = {1'b0, mem[rd_q]};
  assign out_msg_nd = (state_q == HEADER) || (state_q == SEND);
  assign out_msg    = (state_q == HEADER) ? header :
                      (state_q == SEND)   ? payload : last_q;
  assign ready      = (state_q == IDLE);
  assign error      = err_q;

endmodule

// File: tb/tb_msg_framer.sv
// Self-checking bench for msg_framer: cycle table, directed corner cases and
// randomized messages checked against a transaction-level expectation model.
module tb_msg_framer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_start;
  logic [6:0]  in_type;
  logic [30:0] in_word;
  logic        in_word_nd;
  logic        in_end;
  logic        ready;
  logic [31:0] out_msg;
  logic        out_msg_nd;
  logic        error;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  logic [15:0] exp_seq;
  logic        exp_err;

  msg_framer #(.MSG_WIDTH(32), .TYPE_WIDTH(7), .LEN_WIDTH(8), .DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_start(in_start), .in_type(in_type),
    .in_word(in_word), .in_word_nd(in_word_nd), .in_end(in_end),
    .ready(ready), .out_msg(out_msg), .out_msg_nd(out_msg_nd), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic [6:0]  ty;
    logic [30:0] w;
    logic        nd;
    logic        en;
    logic        rdy;
    logic        ond;
    logic [31:0] om;
    logic        er;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    in_start   = 1'b0;
    in_type    = '0;
    in_word    = '0;
    in_word_nd = 1'b0;
    in_end     = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    exp_seq = '0;
    exp_err = 1'b0;
    check("reset_ready", 32'(ready), 32'd1);
    check("reset_nd", 32'(out_msg_nd), 32'd0);
    check("reset_out", out_msg, 32'd0);
    check("reset_err", 32'(error), 32'd0);
  endtask

  // noise bits: 0 stray start while collecting, 1 stray inputs during output,
  // 2 in_start on the first payload cycle, 3 allow gaps between words
  task automatic send_msg(input logic [6:0] t, input int n, input int noise);
    logic [30:0] w [32];
    int          sent;
    int          nexp;
    bit          first;
    bit          done;
    logic [31:0] last;
    for (int i = 0; i < 32; i++) w[i] = 31'($urandom);
    check("pre_ready", 32'(ready), 32'd1);
    sent = 0;
    first = 1'b1;
    done = 1'b0;
    while (!done) begin
      idle_inputs();
      if (first) begin
        in_start = 1'b1;
        in_type  = t;
      end else if (noise[0] && $urandom_range(0, 5) == 0) begin
        in_start = 1'b1;
        in_type  = ~t;
        exp_err  = 1'b1;
      end
      if (sent < n && (!noise[3] || $urandom_range(0, 3) != 0)) begin
        in_word    = w[sent];
        in_word_nd = 1'b1;
        sent++;
      end
      if (sent == n && $urandom_range(0, 1) == 0) begin
        in_end = 1'b1;
        done   = 1'b1;
      end
      first = 1'b0;
      tick();
      if (!done) begin
        check("collect_nd", 32'(out_msg_nd), 32'd0);
        check("collect_ready", 32'(ready), 32'd0);
      end
    end
    nexp = (n > 16) ? 16 : n;
    if (n > 16) exp_err = 1'b1;
    check("hdr_nd", 32'(out_msg_nd), 32'd1);
    check("hdr_word", out_msg, {1'b1, t, 8'(nexp), exp_seq});
    last = {1'b1, t, 8'(nexp), exp_seq};
    exp_seq = exp_seq + 16'd1;
    for (int i = 0; i < nexp; i++) begin
      idle_inputs();
      if (noise[1]) begin
        if ($urandom_range(0, 5) == 0) in_start = 1'b1;
        if ($urandom_range(0, 5) == 0) in_word_nd = 1'b1;
        if ($urandom_range(0, 5) == 0) in_end = 1'b1;
        in_word = 31'($urandom);
        if (in_start || in_word_nd || in_end) exp_err = 1'b1;
      end
      if (noise[2] && i == 1) begin
        in_start = 1'b1;
        in_type  = 7'h7f;
        exp_err  = 1'b1;
      end
      tick();
      check("pay_nd", 32'(out_msg_nd), 32'd1);
      check("pay_word", out_msg, {1'b0, w[i]});
      last = {1'b0, w[i]};
    end
    idle_inputs();
    tick();
    check("end_nd", 32'(out_msg_nd), 32'd0);
    check("end_ready", 32'(ready), 32'd1);
    check("end_hold", out_msg, last);
    check("end_err", 32'(error), 32'(exp_err));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b1, 7'h05, 31'h11, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0};
    tbl[1] = '{1'b0, 7'h00, 31'h22, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0};
    tbl[2] = '{1'b0, 7'h00, 31'h33, 1'b1, 1'b1, 1'b0, 1'b1, 32'h8503_0000, 1'b0};
    tbl[3] = '{1'b0, 7'h00, 31'h00, 1'b0, 1'b0, 1'b0, 1'b1, 32'h11,        1'b0};
    tbl[4] = '{1'b0, 7'h00, 31'h00, 1'b0, 1'b0, 1'b0, 1'b1, 32'h22,        1'b0};
    tbl[5] = '{1'b0, 7'h00, 31'h00, 1'b0, 1'b0, 1'b0, 1'b1, 32'h33,        1'b0};
    tbl[6] = '{1'b0, 7'h00, 31'h00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h33,        1'b0};
    tbl[7] = '{1'b1, 7'h02, 31'h00, 1'b0, 1'b1, 1'b0, 1'b1, 32'h8200_0001, 1'b0};
    tbl[8] = '{1'b0, 7'h00, 31'h00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h8200_0001, 1'b0};
    tbl[9] = '{1'b0, 7'h00, 31'h55, 1'b1, 1'b0, 1'b1, 1'b0, 32'h8200_0001, 1'b1};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      in_start   = tbl[i].st;
      in_type    = tbl[i].ty;
      in_word    = tbl[i].w;
      in_word_nd = tbl[i].nd;
      in_end     = tbl[i].en;
      tick();
      check($sformatf("tbl%0d_ready", i), 32'(ready), 32'(tbl[i].rdy));
      check($sformatf("tbl%0d_nd", i), 32'(out_msg_nd), 32'(tbl[i].ond));
      check($sformatf("tbl%0d_out", i), out_msg, tbl[i].om);
      check($sformatf("tbl%0d_err", i), 32'(error), 32'(tbl[i].er));
    end

    // back-to-back messages, second one empty
    do_reset();
    send_msg(7'h01, 1, 0);
    send_msg(7'h02, 0, 0);

    // overflow, then error stays set through a clean message
    do_reset();
    send_msg(7'h03, 18, 8);
    send_msg(7'h05, 2, 0);

    // in_start while sending must not disturb the stream
    do_reset();
    send_msg(7'h07, 4, 4);

    // reset while the second payload word is on the bus
    do_reset();
    in_start = 1'b1; in_type = 7'h04; in_word = 31'h0a; in_word_nd = 1'b1;
    tick();
    idle_inputs(); in_word = 31'h0b; in_word_nd = 1'b1;
    tick();
    in_word = 31'h0c;
    tick();
    in_word = 31'h0d; in_end = 1'b1;
    tick();
    check("rst_hdr", out_msg, 32'h8404_0000);
    idle_inputs();
    tick();
    check("rst_pay0", out_msg, 32'h0000_000a);
    tick();
    check("rst_pay1", out_msg, 32'h0000_000b);
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    exp_seq = '0;
    exp_err = 1'b0;
    check("rst_nd", 32'(out_msg_nd), 32'd0);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_err", 32'(error), 32'd0);
    send_msg(7'h06, 1, 0);

    // randomized messages with protocol noise
    do_reset();
    for (int m = 0; m < 80; m++) begin
      if ($urandom_range(0, 4) == 0) begin
        idle_inputs();
        if ($urandom_range(0, 1) == 0) in_word_nd = 1'b1;
        else in_end = 1'b1;
        in_word = 31'($urandom);
        exp_err = 1'b1;
        tick();
        check("idle_stray_ready", 32'(ready), 32'd1);
        check("idle_stray_err", 32'(error), 32'd1);
      end
      send_msg(7'($urandom), $urandom_range(0, 19), $urandom_range(0, 15));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
